// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (IF) and load/store (LS).
// One outstanding transaction; simultaneous requests are resolved round-robin.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    if_req_i,
  input  logic [ADDR_WIDTH-1:0]   if_addr_i,
  output logic                    if_gnt_o,
  output logic                    if_rvalid_o,
  output logic [DATA_WIDTH-1:0]   if_rdata_o,
  input  logic                    ls_req_i,
  input  logic                    ls_we_i,
  input  logic [ADDR_WIDTH-1:0]   ls_addr_i,
  input  logic [DATA_WIDTH-1:0]   ls_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] ls_be_i,
  output logic                    ls_gnt_o,
  output logic                    ls_rvalid_o,
  output logic [DATA_WIDTH-1:0]   ls_rdata_o,
  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  output logic [DATA_WIDTH/8-1:0] mem_be_o,
  input  logic                    mem_ready_i,
  input  logic                    mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;
  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_LS = 1'b1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP} state_e;

  state_e                state_q, state_d;
  logic                  owner_q, owner_d;
  logic                  last_owner_q, last_owner_d;
  logic                  mem_req_q, mem_req_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [BE_WIDTH-1:0]   mem_be_q, mem_be_d;
  logic                  if_rvalid_q, if_rvalid_d;
  logic                  ls_rvalid_q, ls_rvalid_d;
  logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_WIDTH-1:0] ls_rdata_q, ls_rdata_d;
  logic                  if_wins;
  logic                  ls_wins;

  // last_owner resets to LS so that IF wins the very first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      owner_q      <= OWN_IF;
      last_owner_q <= OWN_LS;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_be_q     <= '0;
      if_rvalid_q  <= 1'b0;
      ls_rvalid_q  <= 1'b0;
      if_rdata_q   <= '0;
      ls_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_be_q     <= mem_be_d;
      if_rvalid_q  <= if_rvalid_d;
      ls_rvalid_q  <= ls_rvalid_d;
      if_rdata_q   <= if_rdata_d;
      ls_rdata_q   <= ls_rdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_be_d     = mem_be_q;
    if_rvalid_d  = 1'b0;
    ls_rvalid_d  = 1'b0;
    if_rdata_d   = if_rdata_q;
    ls_rdata_d   = ls_rdata_q;
    if_gnt_o     = 1'b0;
    ls_gnt_o     = 1'b0;
    if_wins      = if_req_i && (!ls_req_i || (last_owner_q == OWN_LS));
    ls_wins      = ls_req_i && !if_wins;

    unique case (state_q)
      IDLE: begin
        if (if_wins) begin
          if_gnt_o     = 1'b1;
          owner_d      = OWN_IF;
          last_owner_d = OWN_IF;
          mem_req_d    = 1'b1;
          mem_we_d     = 1'b0;
          mem_addr_d   = if_addr_i;
          mem_wdata_d  = '0;
          mem_be_d     = '1;
          state_d      = ISSUE;
        end else if (ls_wins) begin
          ls_gnt_o     = 1'b1;
          owner_d      = OWN_LS;
          last_owner_d = OWN_LS;
          mem_req_d    = 1'b1;
          mem_we_d     = ls_we_i;
          mem_addr_d   = ls_addr_i;
          mem_wdata_d  = ls_wdata_i;
          mem_be_d     = ls_be_i;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        if (mem_ready_i) begin
          mem_req_d = 1'b0;
          state_d   = WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        // Store acknowledges pulse rvalid but leave the load data untouched.
        if (mem_rvalid_i) begin
          if (owner_q == OWN_IF) begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = mem_rdata_i;
          end else begin
            ls_rvalid_d = 1'b1;
            if (!mem_we_q) begin
              ls_rdata_d = mem_rdata_i;
            end
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign if_rvalid_o = if_rvalid_q;
  assign ls_rvalid_o = ls_rvalid_q;
  assign if_rdata_o  = if_rdata_q;
  assign ls_rdata_o  = ls_rdata_q;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign mem_be_o    = mem_be_q;

endmodule
